// File: rtl/drca_bus_pkg.sv
// Shared types and helpers for the DRCA tristate bus arbiter.
//   state_e : arbiter FSM encoding (IDLE / DRIVE / TURN)
//   clog2   : ceiling log2, usable in parameter expressions
package drca_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Channel-side signal group of the tristate bus arbiter.
//   req       : per-channel request
//   data_in   : packed channel operands, channel i at [i*N +: N]
//   grant     : one-hot owner or zero
//   bus_valid : bus actively driven
//   owner_id  : current / last owner index
// master = requesting channels, slave = arbiter.
interface tristate_bus_arbiter_if
    import drca_bus_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned C  = 4,
    parameter int unsigned IW = clog2(C)
) ();

    logic [C-1:0]   req;
    logic [C*N-1:0] data_in;
    logic [C-1:0]   grant;
    logic           bus_valid;
    logic [IW-1:0]  owner_id;

    modport master (
        output req, data_in,
        input  grant, bus_valid, owner_id
    );

    modport slave (
        input  req, data_in,
        output grant, bus_valid, owner_id
    );

endinterface

// File: rtl/buffer.sv
// Single-control tristate output buffer.
//   in      : value to drive
//   control : 1 drives in onto out, 0 releases out to high-Z
//   out     : tristate output
module buffer #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] in,
    input  logic         control,
    output wire  [N-1:0] out
);

    assign out = control ? in : {N{1'bz}};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr.
//   req   : per-channel request
//   ptr   : search start index
//   gnt_c : one-hot winner (zero if no request)
//   id_c  : winner index
//   any_c : a winner exists
module rr_arbiter
    import drca_bus_pkg::*;
#(
    parameter int unsigned C  = 4,
    parameter int unsigned IW = clog2(C)
) (
    input  logic [C-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [C-1:0]  gnt_c,
    output logic [IW-1:0] id_c,
    output logic          any_c
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk ptr, ptr+1, ... wrapping at C; first hit wins.
    always_comb begin
        gnt_c = '0;
        id_c  = '0;
        any_c = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < C; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(C)) sum = sum - (IW+1)'(C);
            idx = sum[IW-1:0];
            if (!any_c && req[idx]) begin
                any_c      = 1'b1;
                gnt_c[idx] = 1'b1;
                id_c       = idx;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of one N-bit tristate bus shared by C channels.
// Winner's operand is registered (data_q) and driven while bus_valid;
// bursts are capped at MAX_BURST beats when other channels wait.
//   clk, rst_n : clock, async active-low reset
//   bif        : req / data_in in, grant / bus_valid / owner_id out
//   bus        : tristate bus (data_q or high-Z); kept as a plain port so
//                the Z drive is not routed through interface hierarchy
// Build option: TURNAROUND_EN inserts a 1-cycle high-Z TURN state on every
// release; without it handover is zero-gap.
module tristate_bus_arbiter
    import drca_bus_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned C         = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tristate_bus_arbiter_if.slave bif,
    output wire  [N-1:0]          bus
);

    localparam int unsigned IW = clog2(C);
    localparam int unsigned CW = clog2(MAX_BURST + 1);

    state_e        state_q, state_d;
    logic [C-1:0]  grant_q, grant_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [N-1:0]  data_q, data_d;
    logic [IW-1:0] rr_ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          start_c;
    logic          rel_c;
    logic          cnt_sat_c;
    logic [IW-1:0] owner_inc_c;
    logic [IW-1:0] arb_ptr_c;
    logic [C-1:0]  arb_gnt_c;
    logic [IW-1:0] arb_id_c;
    logic          arb_any_c;

    function automatic logic [N-1:0] chan_data(input logic [C*N-1:0] d,
                                               input logic [IW-1:0]  id);
        return N'(d >> (32'(id) * N));
    endfunction

    assign cnt_sat_c   = (cnt_q == CW'(MAX_BURST));
    assign owner_inc_c = (owner_q == IW'(C - 1)) ? '0 : owner_q + IW'(1);
    // Owner drops its request, or is preempted after a full burst.
    assign rel_c       = (state_q == ST_DRIVE) &&
                         (!bif.req[owner_q] || (cnt_sat_c && |(bif.req & ~grant_q)));
    // A same-edge handover must already search from owner+1.
    assign arb_ptr_c   = rel_c ? owner_inc_c : rr_ptr_q;

    rr_arbiter #(.C(C), .IW(IW)) u_rr (
        .req   (bif.req),
        .ptr   (arb_ptr_c),
        .gnt_c (arb_gnt_c),
        .id_c  (arb_id_c),
        .any_c (arb_any_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            owner_q  <= '0;
            data_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            rr_ptr_q <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        owner_d = owner_q;
        data_d  = data_q;
        ptr_d   = rr_ptr_q;
        cnt_d   = cnt_q;
        start_c = 1'b0;

        case (state_q)
            ST_DRIVE: begin
                if (rel_c) begin
                    ptr_d = owner_inc_c;
`ifdef TURNAROUND_EN
                    state_d = ST_TURN;
                    grant_d = '0;
                    valid_d = 1'b0;
`else
                    start_c = arb_any_c;
                    if (!arb_any_c) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
`endif
                end else begin
                    data_d = chan_data(bif.data_in, owner_q);
                    if (!cnt_sat_c) cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE, ST_TURN: begin
                start_c = arb_any_c;
                if (!arb_any_c) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase

        // New owner: capture its first beat now, drive it next cycle.
        if (start_c) begin
            state_d = ST_DRIVE;
            grant_d = arb_gnt_c;
            valid_d = 1'b1;
            owner_d = arb_id_c;
            data_d  = chan_data(bif.data_in, arb_id_c);
            cnt_d   = CW'(1);
        end
    end

    assign bif.grant     = grant_q;
    assign bif.bus_valid = valid_q;
    assign bif.owner_id  = owner_q;

    buffer #(.N(N)) u_buf (
        .in      (data_q),
        .control (valid_q),
        .out     (bus)
    );

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
module tb_tristate_bus_arbiter;

    localparam int unsigned N    = 8;
    localparam int unsigned C    = 4;
    localparam int          MB_A = 4;
    localparam int          MB_B = 1;
`ifdef TURNAROUND_EN
    localparam bit TA = 1'b1;
`else
    localparam bit TA = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [C-1:0]   req;
    logic [C*N-1:0] data_in;
    wire  [N-1:0]   bus_a;
    wire  [N-1:0]   bus_b;

    int n_checks;
    int n_errors;

    tristate_bus_arbiter_if #(.N(N), .C(C)) bif_a ();
    tristate_bus_arbiter_if #(.N(N), .C(C)) bif_b ();

    assign bif_a.req     = req;
    assign bif_a.data_in = data_in;
    assign bif_b.req     = req;
    assign bif_b.data_in = data_in;

    tristate_bus_arbiter #(.N(N), .C(C), .MAX_BURST(MB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bif(bif_a), .bus(bus_a));
    tristate_bus_arbiter #(.N(N), .C(C), .MAX_BURST(MB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bif(bif_b), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner (-1 = bus free), beats in current burst,
    // round-robin start, last owner, operand currently on the bus.
    int           m_owner[2];
    int           m_beats[2];
    int           m_ptr[2];
    int           m_last[2];
    logic [N-1:0] m_data[2];

    logic [C-1:0] hg_a[$];
    logic         hv_a[$];
    logic [N-1:0] hd_a[$];
    int           ho_b[$];
    logic         hv_b[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [C*N-1:0] rand_data();
        return (C*N)'($urandom);
    endfunction

    function automatic int pick(input int p, input logic [C-1:0] r);
        logic [C-1:0] sh;
        int           i;
        for (int k = 0; k < int'(C); k++) begin
            i  = (p + k) % int'(C);
            sh = r >> i;
            if (sh[0]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_beats[m] = 0;
            m_ptr[m]   = 0;
            m_last[m]  = 0;
            m_data[m]  = '0;
        end
    endtask

    task automatic model_take(input int m, input int w, input logic [C*N-1:0] d);
        m_owner[m] = w;
        m_last[m]  = w;
        m_beats[m] = 1;
        m_data[m]  = N'(d >> (w * int'(N)));
    endtask

    // One rising edge of the model with inputs r, d.
    task automatic model_edge(input int m, input logic [C-1:0] r, input logic [C*N-1:0] d);
        int           mb;
        int           o;
        int           w;
        bit           others;
        bit           rel;
        logic [C-1:0] sh;
        mb = (m == 0) ? MB_A : MB_B;
        o  = m_owner[m];
        if (o >= 0) begin
            sh     = r >> o;
            others = (r & ~(C'(1) << o)) != '0;
            rel    = !sh[0] || (m_beats[m] == mb && others);
            if (rel) begin
                m_ptr[m] = (o + 1) % int'(C);
                if (TA) begin
                    m_owner[m] = -1;
                end else begin
                    w = pick(m_ptr[m], r);
                    if (w >= 0) model_take(m, w, d);
                    else        m_owner[m] = -1;
                end
            end else begin
                m_data[m]  = N'(d >> (o * int'(N)));
                m_beats[m] = (m_beats[m] < mb) ? m_beats[m] + 1 : mb;
            end
        end else begin
            w = pick(m_ptr[m], r);
            if (w >= 0) model_take(m, w, d);
        end
    endtask

    task automatic compare_dut(input int m);
        logic [C-1:0] g;
        logic [C-1:0] eg;
        logic         v;
        logic [1:0]   o;
        logic [N-1:0] b;
        if (m == 0) begin
            g = bif_a.grant; v = bif_a.bus_valid; o = bif_a.owner_id; b = bus_a;
        end else begin
            g = bif_b.grant; v = bif_b.bus_valid; o = bif_b.owner_id; b = bus_b;
        end
        eg = (m_owner[m] >= 0) ? (C'(1) << m_owner[m]) : '0;
        check_eq($sformatf("grant%0d", m), 32'(g), 32'(eg));
        check_eq($sformatf("valid%0d", m), 32'(v), 32'(m_owner[m] >= 0));
        check_eq($sformatf("owner_id%0d", m), 32'(o), 32'(m_last[m]));
        if (m_owner[m] >= 0) check_eq($sformatf("bus%0d", m), 32'(b), 32'(m_data[m]));
        if (m == 0) begin
            hg_a.push_back(g); hv_a.push_back(v); hd_a.push_back(b);
        end else begin
            ho_b.push_back(int'(o)); hv_b.push_back(v);
        end
    endtask

    // Check the current cycle, then present new inputs for the next edge.
    task automatic step(input logic [C-1:0] r, input logic [C*N-1:0] d);
        @(negedge clk);
        compare_dut(0);
        compare_dut(1);
        req     = r;
        data_in = d;
        model_edge(0, r, d);
        model_edge(1, r, d);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_edge(0, req, data_in);
        model_edge(1, req, data_in);
        hg_a.delete(); hv_a.delete(); hd_a.delete();
        ho_b.delete(); hv_b.delete();
    endtask

    task automatic do_reset(input logic [C-1:0] r);
        @(negedge clk);
        rst_n   = 1'b0;
        req     = r;
        data_in = rand_data();
        model_reset();
        #1;
        check_eq("rst_grant_a", 32'(bif_a.grant), 32'd0);
        check_eq("rst_valid_a", 32'(bif_a.bus_valid), 32'd0);
        check_eq("rst_owner_a", 32'(bif_a.owner_id), 32'd0);
        check_eq("rst_grant_b", 32'(bif_b.grant), 32'd0);
        check_eq("rst_valid_b", 32'(bif_b.bus_valid), 32'd0);
        @(negedge clk);
        check_eq("rst_hold_grant_a", 32'(bif_a.grant), 32'd0);
        release_reset();
    endtask

    initial begin
        logic [C*N-1:0] d;
        logic [C-1:0]   r;
        int             run;
        int             nxt;
        int             seq[$];
        int             exp_seq[5];
        int             cnt;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = '0;
        data_in  = '0;
        model_reset();

        // Reset with all requests high, then first grant one cycle after release.
        do_reset(4'b1111);
        step(4'b1111, rand_data());
        check_eq("t1_first_grant", 32'(hg_a[0]), 32'h1);

        // Single requester ch2 with operand A5.
        do_reset(4'b0000);
        d = rand_data();
        d[2*N +: N] = 8'hA5;
        step(4'b0100, d);
        step(4'b0100, rand_data());
        step(4'b0000, rand_data());
        step(4'b0000, rand_data());
        check_eq("t2_grant", 32'(hg_a[1]), 32'h4);
        check_eq("t2_bus", 32'(hd_a[1]), 32'hA5);
        check_eq("t2_release", 32'(hv_a[3]), 32'd0);

        // Preemption: ch0 and ch1 held, ch0 gets exactly MAX_BURST beats.
        do_reset(4'b0011);
        for (int i = 0; i < 12; i++) step(4'b0011, rand_data());
        run = 0;
        while (run < hg_a.size() && hg_a[run] == 4'b0001) run++;
        check_eq("t3_burst_len", 32'(run), 32'(MB_A));
        check_eq("t3_handover_valid", 32'(hv_a[4]), 32'(!TA));
        nxt = 4;
        while (nxt < hg_a.size() && hg_a[nxt] == '0) nxt++;
        check_eq("t3_next_owner", 32'(hg_a[nxt]), 32'h2);

        // Fairness with MAX_BURST=1 under full contention.
        do_reset(4'b1111);
        for (int i = 0; i < 10; i++) step(4'b1111, rand_data());
        for (int i = 0; i < ho_b.size(); i++)
            if (hv_b[i] && (i == 0 || !hv_b[i-1] || ho_b[i] != ho_b[i-1]))
                seq.push_back(ho_b[i]);
        exp_seq = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("t4_seq%0d", k),
                     32'((k < seq.size()) ? seq[k] : -1), 32'(exp_seq[k]));

        // Sole requester keeps the bus past MAX_BURST.
        do_reset(4'b1000);
        for (int i = 0; i < 10; i++) step(4'b1000, rand_data());
        cnt = 0;
        foreach (hg_a[i]) if (hg_a[i] == 4'b1000 && hv_a[i]) cnt++;
        check_eq("t5_sole_beats", 32'(cnt), 32'd10);

        // Async reset between edges mid-burst.
        do_reset(4'b0001);
        for (int i = 0; i < 3; i++) step(4'b0001, rand_data());
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_grant_a", 32'(bif_a.grant), 32'd0);
        check_eq("t6_valid_a", 32'(bif_a.bus_valid), 32'd0);
        check_eq("t6_grant_b", 32'(bif_b.grant), 32'd0);
        check_eq("t6_valid_b", 32'(bif_b.bus_valid), 32'd0);
        model_reset();
        release_reset();

        // Random phase: requests toggle with probability 1/4 per bit per cycle.
        r = req;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < int'(C); b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            step(r, rand_data());
        end
        step('0, rand_data());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
